// File: rtl/ifu_lsu_mem_arb_pkg.sv
// rtl/ifu_lsu_mem_arb_pkg.sv - widths, FSM and owner encodings for the IFU/LSU memory arbiter
package ifu_lsu_mem_arb_pkg;

  localparam int PC_SIZE = 32;
  localparam int XLEN    = 32;
  localparam int AW      = PC_SIZE;
  localparam int DW      = XLEN;
  localparam int MW      = DW / 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RSP  = 2'd2
  } arb_state_e;

  localparam logic ARB_OWN_IFU = 1'b0;
  localparam logic ARB_OWN_LSU = 1'b1;

  // One-hot grant vector (bit 0 = IFU, bit 1 = LSU) to owner encoding.
  function automatic logic gnt_to_owner(input logic [1:0] gnt);
    return gnt[1] ? ARB_OWN_LSU : ARB_OWN_IFU;
  endfunction

endpackage

// File: rtl/ifu_lsu_mem_arb_rr_arb2.sv
// rtl/ifu_lsu_mem_arb_rr_arb2.sv - two-way round-robin picker, purely combinational
module ifu_lsu_mem_arb_rr_arb2
  import ifu_lsu_mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // A lone requester always wins; on a conflict the one not granted last time wins.
  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b11) begin
      gnt_o = (last_i == ARB_OWN_LSU) ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/ifu_lsu_mem_arb.sv
// rtl/ifu_lsu_mem_arb.sv - shares one memory port between fetch and load/store, one transaction in flight
module ifu_lsu_mem_arb
  import ifu_lsu_mem_arb_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          ifu_req_valid_i,
  output logic          ifu_req_ready_o,
  input  logic [AW-1:0] ifu_req_pc_i,
  output logic          ifu_rsp_valid_o,
  input  logic          ifu_rsp_ready_i,
  output logic [DW-1:0] ifu_rsp_instr_o,
  input  logic          lsu_req_valid_i,
  output logic          lsu_req_ready_o,
  input  logic [AW-1:0] lsu_req_addr_i,
  input  logic          lsu_req_wen_i,
  input  logic [DW-1:0] lsu_req_wdata_i,
  input  logic [MW-1:0] lsu_req_wmask_i,
  output logic          lsu_rsp_valid_o,
  input  logic          lsu_rsp_ready_i,
  output logic [DW-1:0] lsu_rsp_rdata_o,
  output logic          mem_req_valid_o,
  input  logic          mem_req_ready_i,
  output logic [AW-1:0] mem_req_addr_o,
  output logic          mem_req_wen_o,
  output logic [DW-1:0] mem_req_wdata_o,
  output logic [MW-1:0] mem_req_wmask_o,
  input  logic          mem_rsp_valid_i,
  output logic          mem_rsp_ready_o,
  input  logic [DW-1:0] mem_rsp_rdata_i,
  output logic          arb_owner_o
);

  arb_state_e    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wen_q, wen_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [MW-1:0] wmask_q, wmask_d;
  logic [1:0]    gnt;
  logic          own_rsp_ready;

  ifu_lsu_mem_arb_rr_arb2 u_rr_arb2 (
    .req_i  ({lsu_req_valid_i, ifu_req_valid_i}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign own_rsp_ready = (owner_q == ARB_OWN_LSU) ? lsu_rsp_ready_i : ifu_rsp_ready_i;

  // Next state, grant-time field capture and all handshake outputs.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_d          = last_q;
    addr_d          = addr_q;
    wen_d           = wen_q;
    wdata_d         = wdata_q;
    wmask_d         = wmask_q;
    ifu_req_ready_o = 1'b0;
    lsu_req_ready_o = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_rsp_ready_o = 1'b0;
    ifu_rsp_valid_o = 1'b0;
    lsu_rsp_valid_o = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        // Readies are gated by reset so a requester held valid through reset sees no grant.
        ifu_req_ready_o = gnt[0] & rst_ni;
        lsu_req_ready_o = gnt[1] & rst_ni;
        if (gnt != 2'b00) begin
          state_d = ARB_REQ;
          owner_d = gnt_to_owner(gnt);
          last_d  = gnt_to_owner(gnt);
          if (gnt[1]) begin
            addr_d  = lsu_req_addr_i;
            wen_d   = lsu_req_wen_i;
            wdata_d = lsu_req_wdata_i;
            wmask_d = lsu_req_wmask_i;
          end else begin
            addr_d  = ifu_req_pc_i;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end
      ARB_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) begin
          state_d = ARB_RSP;
        end
      end
      ARB_RSP: begin
        mem_rsp_ready_o = own_rsp_ready;
        ifu_rsp_valid_o = (owner_q == ARB_OWN_IFU) & mem_rsp_valid_i;
        lsu_rsp_valid_o = (owner_q == ARB_OWN_LSU) & mem_rsp_valid_i;
        if (mem_rsp_valid_i && own_rsp_ready) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and latched request fields; last_q resets to LSU so IFU wins the first conflict.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      owner_q <= ARB_OWN_IFU;
      last_q  <= ARB_OWN_LSU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  assign mem_req_addr_o  = addr_q;
  assign mem_req_wen_o   = wen_q;
  assign mem_req_wdata_o = wdata_q;
  assign mem_req_wmask_o = wmask_q;
  assign arb_owner_o     = owner_q;
  assign ifu_rsp_instr_o = mem_rsp_rdata_i;
  assign lsu_rsp_rdata_o = mem_rsp_rdata_i;

endmodule

// File: tb/tb_ifu_lsu_mem_arb.sv
// tb/tb_ifu_lsu_mem_arb.sv - directed and randomized checks of the IFU/LSU memory arbiter
module tb_ifu_lsu_mem_arb;
  import ifu_lsu_mem_arb_pkg::*;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          ifu_req_valid_i, ifu_req_ready_o;
  logic [AW-1:0] ifu_req_pc_i;
  logic          ifu_rsp_valid_o, ifu_rsp_ready_i;
  logic [DW-1:0] ifu_rsp_instr_o;
  logic          lsu_req_valid_i, lsu_req_ready_o;
  logic [AW-1:0] lsu_req_addr_i;
  logic          lsu_req_wen_i;
  logic [DW-1:0] lsu_req_wdata_i;
  logic [MW-1:0] lsu_req_wmask_i;
  logic          lsu_rsp_valid_o, lsu_rsp_ready_i;
  logic [DW-1:0] lsu_rsp_rdata_o;
  logic          mem_req_valid_o, mem_req_ready_i;
  logic [AW-1:0] mem_req_addr_o;
  logic          mem_req_wen_o;
  logic [DW-1:0] mem_req_wdata_o;
  logic [MW-1:0] mem_req_wmask_o;
  logic          mem_rsp_valid_i, mem_rsp_ready_o;
  logic [DW-1:0] mem_rsp_rdata_i;
  logic          arb_owner_o;

  int n_cmp = 0;
  int n_err = 0;

  logic          pi, pl, win, last_m;
  logic [31:0]   pc_r, la_r, lw_r;
  logic          lwen_r;
  logic [3:0]    lm_r;

  ifu_lsu_mem_arb dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o), .ifu_req_pc_i(ifu_req_pc_i),
    .ifu_rsp_valid_o(ifu_rsp_valid_o), .ifu_rsp_ready_i(ifu_rsp_ready_i), .ifu_rsp_instr_o(ifu_rsp_instr_o),
    .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o), .lsu_req_addr_i(lsu_req_addr_i),
    .lsu_req_wen_i(lsu_req_wen_i), .lsu_req_wdata_i(lsu_req_wdata_i), .lsu_req_wmask_i(lsu_req_wmask_i),
    .lsu_rsp_valid_o(lsu_rsp_valid_o), .lsu_rsp_ready_i(lsu_rsp_ready_i), .lsu_rsp_rdata_o(lsu_rsp_rdata_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_wen_o(mem_req_wen_o), .mem_req_wdata_o(mem_req_wdata_o), .mem_req_wmask_o(mem_req_wmask_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o), .mem_rsp_rdata_i(mem_rsp_rdata_i),
    .arb_owner_o(arb_owner_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, 32'(obs), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_inputs();
    ifu_req_valid_i = 1'b0; ifu_req_pc_i = '0; ifu_rsp_ready_i = 1'b1;
    lsu_req_valid_i = 1'b0; lsu_req_addr_i = '0; lsu_req_wen_i = 1'b0;
    lsu_req_wdata_i = '0; lsu_req_wmask_i = '0; lsu_rsp_ready_i = 1'b1;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_rdata_i = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk1({tag, "_ifu_req_ready"}, ifu_req_ready_o, 1'b0);
    chk1({tag, "_lsu_req_ready"}, lsu_req_ready_o, 1'b0);
    chk1({tag, "_mem_req_valid"}, mem_req_valid_o, 1'b0);
    chk1({tag, "_mem_rsp_ready"}, mem_rsp_ready_o, 1'b0);
    chk1({tag, "_ifu_rsp_valid"}, ifu_rsp_valid_o, 1'b0);
    chk1({tag, "_lsu_rsp_valid"}, lsu_rsp_valid_o, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_quiet(tag);
    chk1({tag, "_owner"}, arb_owner_o, 1'b0);
    chk({tag, "_addr"}, mem_req_addr_o, 32'h0);
    chk({tag, "_wdata"}, mem_req_wdata_o, 32'h0);
    chk({tag, "_wmask"}, 32'(mem_req_wmask_o), 32'h0);
    chk1({tag, "_wen"}, mem_req_wen_o, 1'b0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clr_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    chk_reset_vals("reset");
    rst_ni = 1'b1;
  endtask

  task automatic chk_req(input string tag, input logic own, input logic [31:0] addr,
                         input logic wen, input logic [31:0] wdata, input logic [3:0] wmask);
    chk1({tag, "_mem_req_valid"}, mem_req_valid_o, 1'b1);
    chk({tag, "_mem_req_addr"}, mem_req_addr_o, addr);
    chk1({tag, "_mem_req_wen"}, mem_req_wen_o, wen);
    chk({tag, "_mem_req_wdata"}, mem_req_wdata_o, wdata);
    chk({tag, "_mem_req_wmask"}, 32'(mem_req_wmask_o), 32'(wmask));
    chk1({tag, "_ifu_req_ready"}, ifu_req_ready_o, 1'b0);
    chk1({tag, "_lsu_req_ready"}, lsu_req_ready_o, 1'b0);
    chk1({tag, "_owner"}, arb_owner_o, own);
  endtask

  // Entered in the first cycle after the grant; returns in the IDLE cycle after the response.
  task automatic serve(input string tag, input logic own, input logic [31:0] addr, input logic wen,
                       input logic [31:0] wdata, input logic [3:0] wmask,
                       input int req_wait, input int rsp_wait, input int bp, input logic [31:0] rdata);
    mem_req_ready_i = 1'b0;
    for (int i = 0; i < req_wait; i++) begin
      #1; chk_req({tag, "_reqwait"}, own, addr, wen, wdata, wmask);
      tick();
    end
    mem_req_ready_i = 1'b1;
    mem_rsp_valid_i = 1'($urandom_range(0, 1));
    mem_rsp_rdata_i = $urandom;
    #1; chk_req({tag, "_reqhs"}, own, addr, wen, wdata, wmask);
    chk1({tag, "_reqhs_ifu_rsp_valid"}, ifu_rsp_valid_o, 1'b0);
    chk1({tag, "_reqhs_lsu_rsp_valid"}, lsu_rsp_valid_o, 1'b0);
    tick();
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    for (int i = 0; i < rsp_wait; i++) begin
      #1;
      chk1({tag, "_rspwait_ifu_rsp_valid"}, ifu_rsp_valid_o, 1'b0);
      chk1({tag, "_rspwait_lsu_rsp_valid"}, lsu_rsp_valid_o, 1'b0);
      chk1({tag, "_rspwait_mem_req_valid"}, mem_req_valid_o, 1'b0);
      tick();
    end
    mem_rsp_valid_i = 1'b1;
    mem_rsp_rdata_i = rdata;
    if (own) lsu_rsp_ready_i = 1'b0; else ifu_rsp_ready_i = 1'b0;
    for (int i = 0; i < bp; i++) begin
      #1;
      chk1({tag, "_bp_mem_rsp_ready"}, mem_rsp_ready_o, 1'b0);
      chk1({tag, "_bp_ifu_rsp_valid"}, ifu_rsp_valid_o, !own);
      chk1({tag, "_bp_lsu_rsp_valid"}, lsu_rsp_valid_o, own);
      chk1({tag, "_bp_ifu_req_ready"}, ifu_req_ready_o, 1'b0);
      chk1({tag, "_bp_lsu_req_ready"}, lsu_req_ready_o, 1'b0);
      chk1({tag, "_bp_mem_req_valid"}, mem_req_valid_o, 1'b0);
      tick();
    end
    if (own) lsu_rsp_ready_i = 1'b1; else ifu_rsp_ready_i = 1'b1;
    #1;
    chk1({tag, "_rsp_mem_rsp_ready"}, mem_rsp_ready_o, 1'b1);
    chk1({tag, "_rsp_ifu_rsp_valid"}, ifu_rsp_valid_o, !own);
    chk1({tag, "_rsp_lsu_rsp_valid"}, lsu_rsp_valid_o, own);
    chk({tag, "_rsp_data"}, own ? lsu_rsp_rdata_o : ifu_rsp_instr_o, rdata);
    chk1({tag, "_rsp_ifu_req_ready"}, ifu_req_ready_o, 1'b0);
    chk1({tag, "_rsp_lsu_req_ready"}, lsu_req_ready_o, 1'b0);
    chk1({tag, "_rsp_owner"}, arb_owner_o, own);
    tick();
    mem_rsp_valid_i = 1'b0;
  endtask

  initial begin
    pi = 1'b0; pl = 1'b0; win = 1'b0; last_m = 1'b1;
    pc_r = '0; la_r = '0; lw_r = '0; lwen_r = 1'b0; lm_r = '0;
    clr_inputs();

    // IFU alone with zero-wait memory: grant, request, response in consecutive cycles.
    do_reset();
    ifu_req_valid_i = 1'b1; ifu_req_pc_i = 32'h8000_0000; mem_req_ready_i = 1'b1;
    #1;
    chk1("t1_ifu_req_ready", ifu_req_ready_o, 1'b1);
    chk1("t1_lsu_req_ready", lsu_req_ready_o, 1'b0);
    tick();
    ifu_req_valid_i = 1'b0; ifu_req_pc_i = 32'hFFFF_FFFF;
    #1;
    chk_req("t1_c1", 1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0);
    tick();
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = 32'h0000_0413;
    #1;
    chk1("t1_ifu_rsp_valid", ifu_rsp_valid_o, 1'b1);
    chk("t1_ifu_rsp_instr", ifu_rsp_instr_o, 32'h0000_0413);
    chk1("t1_lsu_rsp_valid", lsu_rsp_valid_o, 1'b0);
    chk1("t1_mem_rsp_ready", mem_rsp_ready_o, 1'b1);
    tick();
    mem_rsp_valid_i = 1'b0;

    // Back-to-back conflicts out of reset: IFU, then LSU, then IFU.
    do_reset();
    ifu_req_valid_i = 1'b1; ifu_req_pc_i = 32'h8000_0004;
    lsu_req_valid_i = 1'b1; lsu_req_addr_i = 32'h8000_1000; lsu_req_wen_i = 1'b0;
    #1;
    chk1("t2_g1_ifu_ready", ifu_req_ready_o, 1'b1);
    chk1("t2_g1_lsu_ready", lsu_req_ready_o, 1'b0);
    tick();
    ifu_req_valid_i = 1'b0;
    serve("t2_x1", 1'b0, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 0, 0, 0, 32'h1111_0001);
    ifu_req_valid_i = 1'b1; ifu_req_pc_i = 32'h8000_0008;
    #1;
    chk1("t2_g2_ifu_ready", ifu_req_ready_o, 1'b0);
    chk1("t2_g2_lsu_ready", lsu_req_ready_o, 1'b1);
    tick();
    lsu_req_valid_i = 1'b0;
    serve("t2_x2", 1'b1, 32'h8000_1000, 1'b0, 32'h0, 4'h0, 0, 0, 0, 32'h2222_0002);
    lsu_req_valid_i = 1'b1; lsu_req_addr_i = 32'h8000_1004;
    #1;
    chk1("t2_g3_ifu_ready", ifu_req_ready_o, 1'b1);
    chk1("t2_g3_lsu_ready", lsu_req_ready_o, 1'b0);
    tick();
    ifu_req_valid_i = 1'b0;
    serve("t2_x3", 1'b0, 32'h8000_0008, 1'b0, 32'h0, 4'h0, 0, 0, 0, 32'h3333_0003);
    #1;
    chk1("t2_g4_lsu_ready", lsu_req_ready_o, 1'b1);
    tick();
    lsu_req_valid_i = 1'b0;
    serve("t2_x4", 1'b1, 32'h8000_1004, 1'b0, 32'h0, 4'h0, 0, 0, 0, 32'h4444_0004);

    // LSU store with a slow memory: latched fields stay put while inputs change.
    lsu_req_valid_i = 1'b1; lsu_req_addr_i = 32'h8000_2000; lsu_req_wen_i = 1'b1;
    lsu_req_wdata_i = 32'hDEAD_BEEF; lsu_req_wmask_i = 4'hF;
    #1;
    chk1("t3_lsu_ready", lsu_req_ready_o, 1'b1);
    tick();
    lsu_req_valid_i = 1'b0; lsu_req_addr_i = 32'h1234_5678; lsu_req_wen_i = 1'b0;
    lsu_req_wdata_i = 32'h0BAD_F00D; lsu_req_wmask_i = 4'h3;
    serve("t3_st", 1'b1, 32'h8000_2000, 1'b1, 32'hDEAD_BEEF, 4'hF, 3, 0, 0, 32'h5555_0005);

    // Owner backpressure for four cycles while LSU waits; LSU granted only in the next IDLE.
    ifu_req_valid_i = 1'b1; ifu_req_pc_i = 32'h8000_0010;
    #1;
    chk1("t4_ifu_ready", ifu_req_ready_o, 1'b1);
    tick();
    ifu_req_valid_i = 1'b0;
    lsu_req_valid_i = 1'b1; lsu_req_addr_i = 32'h8000_3000; lsu_req_wen_i = 1'b0;
    lsu_req_wdata_i = '0; lsu_req_wmask_i = '0;
    serve("t4_bp", 1'b0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, 1, 4, 32'h6666_0006);
    #1;
    chk1("t4_lsu_ready_after", lsu_req_ready_o, 1'b1);
    chk1("t4_ifu_ready_after", ifu_req_ready_o, 1'b0);
    tick();
    lsu_req_valid_i = 1'b0;
    serve("t4_ld", 1'b1, 32'h8000_3000, 1'b0, 32'h0, 4'h0, 0, 0, 0, 32'h7777_0007);

    // Spurious memory response in IDLE is ignored.
    mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = 32'hCAFE_0000;
    #1;
    chk_quiet("t5_spurious");
    tick();
    mem_rsp_valid_i = 1'b0;

    // Asynchronous reset during REQ, then a fresh fetch.
    ifu_req_valid_i = 1'b1; ifu_req_pc_i = 32'h8000_0020;
    #1;
    chk1("t6_ifu_ready", ifu_req_ready_o, 1'b1);
    tick();
    ifu_req_valid_i = 1'b0;
    #1;
    chk1("t6_in_req", mem_req_valid_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk_reset_vals("t6_async");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    ifu_req_valid_i = 1'b1; ifu_req_pc_i = 32'h8000_0024;
    #1;
    chk1("t6_regrant", ifu_req_ready_o, 1'b1);
    tick();
    ifu_req_valid_i = 1'b0;
    serve("t6_after", 1'b0, 32'h8000_0024, 1'b0, 32'h0, 4'h0, 1, 1, 1, 32'h8888_0008);

    // Random traffic against a transaction-level round-robin model.
    do_reset();
    last_m = 1'b1;
    pi = 1'b0; pl = 1'b0;
    for (int t = 0; t < 150; t++) begin
      if (!pi && $urandom_range(0, 2) != 0) begin
        pi = 1'b1; pc_r = $urandom & 32'hFFFF_FFFC;
      end
      if (!pl && $urandom_range(0, 2) != 0) begin
        pl = 1'b1; la_r = $urandom; lwen_r = 1'($urandom_range(0, 1));
        lw_r = $urandom; lm_r = 4'($urandom_range(0, 15));
      end
      ifu_req_valid_i = pi; ifu_req_pc_i = pc_r;
      lsu_req_valid_i = pl; lsu_req_addr_i = la_r; lsu_req_wen_i = lwen_r;
      lsu_req_wdata_i = lw_r; lsu_req_wmask_i = lm_r;
      mem_rsp_valid_i = 1'($urandom_range(0, 1));
      mem_rsp_rdata_i = $urandom;
      if (!pi && !pl) begin
        #1;
        chk_quiet("rnd_idle");
        tick();
        continue;
      end
      win = (pi && pl) ? ~last_m : pl;
      #1;
      chk1("rnd_ifu_ready", ifu_req_ready_o, !win);
      chk1("rnd_lsu_ready", lsu_req_ready_o, win);
      tick();
      last_m = win;
      mem_rsp_valid_i = 1'b0;
      if (win) begin
        pl = 1'b0;
        lsu_req_valid_i = 1'b0; lsu_req_addr_i = $urandom; lsu_req_wdata_i = $urandom;
        lsu_req_wen_i = 1'($urandom_range(0, 1)); lsu_req_wmask_i = 4'($urandom_range(0, 15));
        serve("rnd_lsu", 1'b1, la_r, lwen_r, lw_r, lm_r,
              $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
      end else begin
        pi = 1'b0;
        ifu_req_valid_i = 1'b0; ifu_req_pc_i = $urandom;
        serve("rnd_ifu", 1'b0, pc_r, 1'b0, 32'h0, 4'h0,
              $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifu_lsu_mem_arb.md
# ifu_lsu_mem_arb

Two-requester arbiter that shares the core's single memory port between instruction fetch (IFU) and data access (LSU). It sits between the IFU/LSU memory interfaces and the memory bus. It uses valid/ready handshakes on every channel and allows exactly one outstanding transaction. Conflicts are resolved round-robin, so neither fetch nor load/store can starve the other.

## Interface
- AW, 32 (`PC_SIZE`): address width
- DW, 32 (`XLEN`): data/instruction width; DW/8 byte lanes
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-low
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted (granted) this cycle
- ifu_req_pc  in  AW  fetch address
- ifu_rsp_valid  out  1  instruction returned
- ifu_rsp_ready  in  1  IFU accepts instruction
- ifu_rsp_instr  out  DW  instruction
- lsu_req_valid  in  1  data request
- lsu_req_ready  out  1  data request accepted
- lsu_req_addr  in  AW  data address
- lsu_req_wen  in  1  1 = store, 0 = load
- lsu_req_wdata  in  DW  store data
- lsu_req_wmask  in  DW/8  store byte enables
- lsu_rsp_valid  out  1  load data / store ack returned
- lsu_rsp_ready  in  1  LSU accepts response
- lsu_rsp_rdata  out  DW  load data (don't-care for stores)
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask  out  AW, 1, DW, DW/8  registered request fields
- mem_rsp_valid / mem_rsp_ready  in / out  1  memory response handshake
- mem_rsp_rdata  in  DW  response data
- arb_owner  out  1  current owner: 0 = IFU, 1 = LSU

## Operation
- FSM states: IDLE, REQ, RSP.
- IDLE: picks a winner among the valid requesters.
  - Winner's req_ready is 1 (combinational from valids and the last-grant bit); the loser's is 0.
  - On grant: latch address, wen, wdata and wmask (IFU: wen = 0, wmask = 0); set owner and last_grant = winner; go to REQ.
- Conflict rule: when both are valid, grant the requester not in last_grant. A lone requester always wins.
- REQ: mem_req_valid = 1, driven from the latched fields. On mem_req_ready, go to RSP.
- RSP:
  - Owner's rsp_valid = mem_rsp_valid; owner's rsp data = mem_rsp_rdata (pass-through).
  - mem_rsp_ready = owner's rsp_ready.
  - Non-owner rsp_valid = 0.
  - On handshake (mem_rsp_valid & owner rsp_ready), go to IDLE.
- Requesters must hold valid and fields stable until ready. Fields are sampled only at grant, so they may change the cycle after.
- All req_ready outputs are 0 outside IDLE.
- mem_rsp_valid outside RSP is ignored; mem_rsp_ready = 0 there.
- Reset values: state IDLE, owner 0, last_grant 1 (IFU wins the first conflict), latched fields 0, every valid/ready output 0, arb_owner 0.

## Timing
- Grant in cycle N; mem_req_valid earliest in cycle N+1.
- Response is combinational pass-through in the cycle mem_rsp_valid arrives.
- Best case, zero-wait memory: one transaction per 3 cycles (IDLE, REQ, RSP).
- mem_req_ready and mem_rsp_valid high in the same REQ cycle: only the request handshake counts; the response is consumed in RSP from the next cycle.
- Backpressure: if owner rsp_ready = 0 in RSP, stay in RSP with the response held by memory (mem_rsp_ready = 0).
- A new request arriving in the cycle of the RSP handshake is not granted until the following IDLE cycle.
- Reset asserted mid-transaction: immediately IDLE, all outputs to reset values. The in-flight transaction is dropped; the memory side is reset by the same rst.

## Structure
- Add to defines.v: ARB_IDLE/ARB_REQ/ARB_RSP encodings (2 bits), owner encodings ARB_OWN_IFU = 0 and ARB_OWN_LSU = 1. Widths come from `PC_SIZE` and `XLEN`.
- Sub-module rr_arb2: 2-way round-robin picker. Inputs req[1:0] and last; outputs a one-hot grant. Purely combinational.
- Top: FSM, latch registers, response routing mux.

## Test plan
- IFU only, pc = 0x8000_0000, mem ready immediately, rdata 0x0000_0413: ifu_req_ready at cycle 0, mem_req_valid with addr 0x8000_0000 and wen 0 at cycle 1, ifu_rsp_instr 0x0000_0413 at cycle 2, lsu_rsp_valid stays 0.
- Both valid out of reset (IFU pc 0x8000_0004, LSU load 0x8000_1000): IFU granted first; LSU granted in the next IDLE; a third back-to-back conflict goes to IFU.
- LSU store addr 0x8000_2000, wdata 0xDEAD_BEEF, wmask 0xF, mem_req_ready delayed 3 cycles: fields stay stable on mem_req_*, lsu_req_ready high exactly 1 cycle, lsu_rsp_valid after ack.
- Owner holds rsp_ready = 0 for 4 cycles with mem_rsp_valid = 1: mem_rsp_ready stays 0, state stays RSP, no new grant; completes on the cycle rsp_ready rises.
- Spurious mem_rsp_valid in IDLE: ignored, no rsp_valid to either requester.
- rst pulled low during REQ: all outputs 0 asynchronously; after release, a fresh IFU request completes normally.
